// File: rtl/knight_pkg.sv
// Shared constants and state encoding for the knight-tour command interface.
package knight_pkg;

    localparam logic [3:0] OP_CAL      = 4'h0;
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_ERR = 8'hEE;

    localparam logic signed [5:0] POS_MAX = 6'sd4;
    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_CAL,
        S_TURN,
        S_MOVE,
        S_FANFARE,
        S_RESP
    } state_e;

endpackage

// File: rtl/cmd_resp_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded interval.
module cmd_resp_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/cmd_responder.sv
// Knight-move command responder: timed heading/travel model with board tracking.
// Optional fanfare phase for opcode 3 enabled by defining CMD_RESP_FANFARE_EN.
module cmd_responder
    import knight_pkg::*;
#(
    parameter int TURN_CYCLES    = 3,
    parameter int SQ_CYCLES      = 4,
    parameter int CAL_CYCLES     = 8,
    parameter int FANFARE_CYCLES = 6,
    parameter int X0             = 2,
    parameter int Y0             = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    output logic        busy,
    output logic        fanfare,
    output logic [2:0]  x_pos,
    output logic [2:0]  y_pos
);

    state_e            state_q, state_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [7:0]        resp_q, resp_d;
    logic [2:0]        x_q, x_d, y_q, y_d;
    logic [2:0]        dx_q, dx_d, dy_q, dy_d;

    logic [3:0]        op;
    logic [7:0]        hdg;
    logic [3:0]        nsq;
    logic signed [5:0] tx, ty;
    logic              hdg_ok, dest_ok, move_op, cmd_err, fan_phase;
    logic              tmr_load, tmr_done;
    logic [TMR_W-1:0]  tmr_val;
    state_e            after_move;

    assign op  = cmd_q[15:12];
    assign hdg = cmd_q[11:4];
    assign nsq = cmd_q[3:0];

    // Destination in 6-bit signed space so out-of-board results never wrap back on.
    always_comb begin
        tx     = {3'b000, x_q};
        ty     = {3'b000, y_q};
        hdg_ok = 1'b1;
        case (hdg)
            HDG_N:   ty = ty + {2'b00, nsq};
            HDG_W:   tx = tx - {2'b00, nsq};
            HDG_S:   ty = ty - {2'b00, nsq};
            HDG_E:   tx = tx + {2'b00, nsq};
            default: hdg_ok = 1'b0;
        endcase
    end

    assign dest_ok = !tx[5] && (tx <= POS_MAX) && !ty[5] && (ty <= POS_MAX);
    assign move_op = (op == OP_MOVE) || (op == OP_MOVE_FAN);
    assign cmd_err = (op != OP_CAL) && (!move_op || !hdg_ok || !dest_ok);

`ifdef CMD_RESP_FANFARE_EN
    assign fan_phase = (op == OP_MOVE_FAN);
    assign fanfare   = (state_q == S_FANFARE);
`else
    assign fan_phase = 1'b0;
    assign fanfare   = 1'b0;
`endif

    assign after_move = fan_phase ? S_FANFARE : S_RESP;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        resp_d  = resp_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_rdy) begin
                    cmd_d   = cmd;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_CAL) begin
                    state_d = S_CAL;
                end else if (cmd_err) begin
                    state_d = S_RESP;
                end else begin
                    dx_d    = tx[2:0];
                    dy_d    = ty[2:0];
                    state_d = S_TURN;
                end
            end
            S_CAL:     if (tmr_done) state_d = S_RESP;
            S_TURN:    if (tmr_done) state_d = (nsq == 4'd0) ? after_move : S_MOVE;
            S_MOVE: begin
                if (tmr_done) begin
                    x_d     = dx_q;
                    y_d     = dy_q;
                    state_d = after_move;
                end
            end
            S_FANFARE: if (tmr_done) state_d = S_RESP;
            // The RESP cycle doubles as an idle slot so a held cmd_rdy is taken on the closing edge.
            S_RESP: begin
                if (cmd_rdy) begin
                    cmd_d   = cmd;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Only an error goes straight from DECODE to RESP.
        if (state_d == S_RESP && state_q != S_RESP)
            resp_d = (state_q == S_DECODE) ? RESP_ERR : RESP_ACK;
    end

    always_comb begin
        tmr_val = '0;
        case (state_d)
            S_TURN:    tmr_val = TMR_W'(TURN_CYCLES);
            S_MOVE:    tmr_val = TMR_W'(nsq) * TMR_W'(SQ_CYCLES);
            S_CAL:     tmr_val = TMR_W'(CAL_CYCLES);
            S_FANFARE: tmr_val = TMR_W'(FANFARE_CYCLES);
            default:   tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q);

    cmd_resp_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            resp_q  <= '0;
            x_q     <= 3'(X0);
            y_q     <= 3'(Y0);
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            resp_q  <= resp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    assign clr_cmd_rdy = (state_q == S_DECODE);
    assign send_resp   = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign resp        = resp_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Self-checking bench for cmd_responder against a cycle-count reference model.
module tb_cmd_responder;

    localparam int T = 3, S = 4, C = 8, F = 6, X0 = 2, Y0 = 2;
`ifdef CMD_RESP_FANFARE_EN
    localparam bit FAN_EN = 1'b1;
`else
    localparam bit FAN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = '0;
    logic        cmd_rdy = 1'b0;
    logic        clr_cmd_rdy, send_resp, busy, fanfare;
    logic [7:0]  resp;
    logic [2:0]  x_pos, y_pos;

    int n_checks = 0;
    int n_pass = 0;
    int mx = X0, my = Y0;

    always #5 clk = ~clk;

    cmd_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .busy        (busy),
        .fanfare     (fanfare),
        .x_pos       (x_pos),
        .y_pos       (y_pos)
    );

    // Expected outcome of one command from board position (x,y).
    function automatic void model(input logic [15:0] c, input int x, input int y,
                                  output int lat, output logic [7:0] r,
                                  output int nx, output int ny, output int fan);
        int op, n, dx, dy, tx, ty;
        bit hok;
        op = int'(c[15:12]);
        n  = int'(c[3:0]);
        dx = 0; dy = 0; hok = 1'b1;
        nx = x; ny = y; fan = 0; lat = 2; r = 8'hEE;
        case (c[11:4])
            8'h00:   dy = 1;
            8'h3F:   dx = -1;
            8'h7F:   dy = -1;
            8'hBF:   dx = 1;
            default: hok = 1'b0;
        endcase
        tx = x + dx * n;
        ty = y + dy * n;
        if (op == 0) begin
            lat = 2 + C;
            r   = 8'hA5;
        end else if ((op == 2 || op == 3) && hok && tx >= 0 && tx <= 4 && ty >= 0 && ty <= 4) begin
            nx  = tx;
            ny  = ty;
            r   = 8'hA5;
            fan = (op == 3 && FAN_EN) ? F : 0;
            lat = 2 + T + n * S + fan;
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; cmd_rdy = 1'b0; cmd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mx = X0; my = Y0;
    endtask

    // Issue one command and observe it; cycle k is the k-th negedge after the capture edge.
    task automatic do_cmd(input logic [15:0] c, input bit hold,
                          output int clr_cyc, output int clr_n, output int rc, output int fc,
                          output bit bok, output logic [7:0] r,
                          output logic [2:0] px, output logic [2:0] py);
        clr_cyc = -1; clr_n = 0; rc = -1; fc = 0; bok = 1'b1;
        r = 'x; px = 'x; py = 'x;
        @(negedge clk);
        cmd = c; cmd_rdy = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (clr_cmd_rdy) begin
                clr_n++;
                if (clr_cyc < 0) clr_cyc = k;
                if (!hold) begin
                    cmd_rdy = 1'b0;
                    cmd = 16'($urandom);
                end
            end
            if (fanfare) fc++;
            if (!busy) bok = 1'b0;
            if (send_resp) begin
                rc = k; r = resp; px = x_pos; py = y_pos;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_rdy = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({clr_cmd_rdy, send_resp, busy, fanfare} !== 4'b0000)
            $display("FAIL reset_ctrl: got clr/send/busy/fan=%b want 0000", {clr_cmd_rdy, send_resp, busy, fanfare});
        else n_pass++;
        n_checks++;
        if (resp !== 8'h00) $display("FAIL reset_resp: got %h want 00", resp);
        else n_pass++;
        n_checks++;
        if (x_pos !== 3'(X0) || y_pos !== 3'(Y0))
            $display("FAIL reset_pos: got (%0d,%0d) want (%0d,%0d)", x_pos, y_pos, X0, Y0);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || send_resp !== 1'b0) $display("FAIL idle_after_reset: busy=%b send=%b want 0 0", busy, send_resp);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] dc[5] = '{16'h2002, 16'h2001, 16'h33F1, 16'h0000, 16'h5000};
        bit          dr[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int clr_cyc, clr_n, rc, fc, lat, nx, ny, fan;
        bit bok;
        logic [7:0] r, er;
        logic [2:0] px, py;
        for (int i = 0; i < 5; i++) begin
            if (dr[i]) apply_reset();
            model(dc[i], mx, my, lat, er, nx, ny, fan);
            do_cmd(dc[i], 1'b0, clr_cyc, clr_n, rc, fc, bok, r, px, py);
            n_checks++;
            if (clr_cyc !== 1 || clr_n !== 1) $display("FAIL dir_clr %h: first=%0d pulses=%0d want 1 1", dc[i], clr_cyc, clr_n);
            else n_pass++;
            n_checks++;
            if (rc !== lat) $display("FAIL dir_latency %h: got %0d want %0d", dc[i], rc, lat);
            else n_pass++;
            n_checks++;
            if (r !== er) $display("FAIL dir_resp %h: got %h want %h", dc[i], r, er);
            else n_pass++;
            n_checks++;
            if (px !== 3'(nx) || py !== 3'(ny)) $display("FAIL dir_pos %h: got (%0d,%0d) want (%0d,%0d)", dc[i], px, py, nx, ny);
            else n_pass++;
            n_checks++;
            if (fc !== fan || !bok) $display("FAIL dir_fan_busy %h: fan=%0d busy_ok=%0d want %0d 1", dc[i], fc, bok, fan);
            else n_pass++;
            mx = nx; my = ny;
        end
    endtask

    task automatic test_random();
        logic [7:0] hdgs[4] = '{8'h00, 8'h3F, 8'h7F, 8'hBF};
        int clr_cyc, clr_n, rc, fc, lat, nx, ny, fan, sel;
        bit bok;
        logic [7:0] r, er, h;
        logic [3:0] op, n;
        logic [15:0] c;
        logic [2:0] px, py;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 5));
            op = (sel == 0) ? 4'h0 : (sel <= 2) ? 4'h2 : (sel == 3) ? 4'h3 : 4'($urandom);
            sel = int'($urandom_range(0, 4));
            h  = (sel < 4) ? hdgs[sel] : 8'($urandom);
            n  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            c  = {op, h, n};
            model(c, mx, my, lat, er, nx, ny, fan);
            do_cmd(c, 1'b0, clr_cyc, clr_n, rc, fc, bok, r, px, py);
            n_checks++;
            if (rc !== lat || clr_cyc !== 1) $display("FAIL rnd_timing %h: resp_cyc=%0d clr=%0d want %0d 1", c, rc, clr_cyc, lat);
            else n_pass++;
            n_checks++;
            if (r !== er) $display("FAIL rnd_resp %h: got %h want %h", c, r, er);
            else n_pass++;
            n_checks++;
            if (px !== 3'(nx) || py !== 3'(ny) || fc !== fan)
                $display("FAIL rnd_pos_fan %h: got (%0d,%0d) fan=%0d want (%0d,%0d) fan=%0d", c, px, py, fc, nx, ny, fan);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (resp !== er || busy !== 1'b0 || send_resp !== 1'b0)
                $display("FAIL rnd_hold %h: resp=%h busy=%b send=%b want %h 0 0", c, resp, busy, send_resp, er);
            else n_pass++;
            mx = nx; my = ny;
        end
    endtask

    task automatic test_back_to_back();
        int clr_cyc, clr_n, rc, fc, clr2, rc2;
        bit bok;
        logic [7:0] r, r2;
        logic [2:0] px, py, py2;
        apply_reset();
        do_cmd(16'h27F1, 1'b1, clr_cyc, clr_n, rc, fc, bok, r, px, py);
        n_checks++;
        if (rc !== 2 + T + S || clr_n !== 1 || r !== 8'hA5 || py !== 3'd1)
            $display("FAIL b2b_first: cyc=%0d pulses=%0d resp=%h y=%0d want %0d 1 a5 1", rc, clr_n, r, py, 2 + T + S);
        else n_pass++;
        clr2 = -1; rc2 = -1; r2 = 'x; py2 = 'x;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (clr_cmd_rdy && clr2 < 0) begin
                clr2 = j;
                cmd_rdy = 1'b0;
            end
            if (send_resp) begin
                rc2 = j; r2 = resp; py2 = y_pos;
                break;
            end
        end
        cmd_rdy = 1'b0;
        n_checks++;
        if (clr2 !== 1) $display("FAIL b2b_capture: second clr in cycle %0d want 1", clr2);
        else n_pass++;
        n_checks++;
        if (rc2 !== 2 + T + S || r2 !== 8'hA5 || py2 !== 3'd0)
            $display("FAIL b2b_second: cyc=%0d resp=%h y=%0d want %0d a5 0", rc2, r2, py2, 2 + T + S);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int clr_cyc, clr_n, rc, fc, seen;
        bit bok;
        logic [7:0] r;
        logic [2:0] px, py;
        apply_reset();
        do_cmd(16'h0000, 1'b0, clr_cyc, clr_n, rc, fc, bok, r, px, py);
        @(negedge clk);
        cmd = 16'h2BF2; cmd_rdy = 1'b1;
        // Cycle 7 lies inside MOVE (cycles 5..12) of an E2 move.
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (clr_cmd_rdy) cmd_rdy = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({clr_cmd_rdy, send_resp, busy, fanfare} !== 4'b0000 || resp !== 8'h00)
            $display("FAIL midrst_outputs: ctrl=%b resp=%h want 0000 00", {clr_cmd_rdy, send_resp, busy, fanfare}, resp);
        else n_pass++;
        n_checks++;
        if (x_pos !== 3'(X0) || y_pos !== 3'(Y0))
            $display("FAIL midrst_pos: got (%0d,%0d) want (%0d,%0d)", x_pos, y_pos, X0, Y0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (send_resp || busy) seen++;
        end
        n_checks++;
        if (seen !== 0 || x_pos !== 3'(X0)) $display("FAIL midrst_quiet: activity=%0d x=%0d want 0 %0d", seen, x_pos, X0);
        else n_pass++;
        mx = X0; my = Y0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
